pocket_hits_display: RTL and testbench
======================================

# pocket_hits_display

Consumer of a pocket object's on-screen anchor. Counts balls sunk into the pockets and draws one marker square per hit, in a row starting at the supplied top-left corner. Count updates are frame-synchronous, so the row never tears mid-frame. Outputs feed the VGA objects mux as a standard drawing-request/RGB pair.

## Interface
Parameters:
- MAX_HITS, 15: count saturation value and number of marker slots (1..31).
- MARKER_SIZE, 10: marker side in pixels (1..16).
- MARKER_COLOR, 8'h00: RGB332 colour of a marker.
- BLINK_FRAMES, 32: length of the newest-marker blink window in frames. Used only with POCKET_HITS_BLINK_EN.

Ports:
- clk, in, 1: system clock.
- resetN, in, 1: asynchronous, active-low reset.
- startOfFrame, in, 1: one-clock pulse at the start of each frame.
- pixelX, in, 11: current scan X (unsigned).
- pixelY, in, 11: current scan Y (unsigned).
- topLeftX, in, 11 signed: X of the row's anchor.
- topLeftY, in, 11 signed: Y of the row's anchor.
- ballInPocket, in, 1: pocket collision. May stay high for many clocks per frame.
- newGame, in, 1: synchronous clear pulse.
- hitCount, out, 5: committed hit count.
- allPocketed, out, 1: high when hitCount == MAX_HITS.
- drawingRequest, out, 1: current pixel is inside a lit marker.
- RGBout, out, 8: MARKER_COLOR when drawingRequest is high, else 8'hFF (transparent).

## Operation
- Any cycle with ballInPocket=1 sets pendingHit.
- Count commit happens on the startOfFrame cycle:
  - If pendingHit=1 and count < MAX_HITS, count increments by 1.
  - pendingHit clears on that cycle regardless.
  - Result: at most one hit per frame.
- ballInPocket high in the same cycle as startOfFrame: pendingHit is re-set after the clear and is committed on the next frame.
- Saturation: when count == MAX_HITS, further hits are dropped and pendingHit still clears.
- newGame has priority over all other inputs. It clears count and pendingHit on the next edge, mid-frame included. A hit on the same cycle is discarded.
- displayCount is a copy of count loaded on the cycle after startOfFrame. Drawing uses displayCount only.
- Geometry:
  - offX = pixelX − topLeftX and offY = pixelY − topLeftY, both computed at 12-bit signed width.
  - The pixel is in the row when 0 ≤ offX < MAX_HITS·16 and 0 ≤ offY < MARKER_SIZE.
  - Slot index = offX[8:4]; in-marker test is offX[3:0] < MARKER_SIZE. Marker pitch is fixed at 16 px.
  - The pixel is lit when it is in the row, in a marker, and index < displayCount.
- If the anchor is partly off-screen (negative topLeft), the row is clipped naturally. There is no wrap-around.

## Timing
- Reset values: hitCount=0, allPocketed=0, drawingRequest=0, RGBout=8'hFF. Internal count, displayCount and pendingHit are also 0.
- Draw pipeline, 2 registered stages:
  - Stage 1 registers offX, offY and the range flags.
  - Stage 2 registers drawingRequest and RGBout.
  - Latency from pixelX/pixelY to the outputs is exactly 2 clocks. One new pixel is accepted per clock.
- hitCount and allPocketed change 1 clock after the startOfFrame (or newGame) edge that commits the change.
- displayCount lags count by 1 clock, so the first pixels of a frame already see the new value.

## Configuration
- POCKET_HITS_BLINK_EN defined:
  - Each committed increment loads a frame counter with BLINK_FRAMES.
  - The counter decrements on every startOfFrame until it reaches 0.
  - While the counter is nonzero, the newest marker (index displayCount−1) is suppressed on frames where counter[2]=1, i.e. it toggles every 4 frames.
  - newGame and reset clear the counter.
- POCKET_HITS_BLINK_EN undefined: all markers below displayCount are steady, and no blink logic is synthesised.

## Test plan
- Reset, then pixel (topLeftX+2, topLeftY+2) with anchor (16,16) → drawingRequest=0 and RGBout=8'hFF after 2 clocks.
- ballInPocket held 500 clocks inside one frame, then startOfFrame → hitCount=1. Pixels (18,18) and (25,25) are lit. Pixel (30,18), a gap column since offX=14, is not lit. Pixel (34,18), slot 1, is not lit.
- ballInPocket asserted in the same cycle as startOfFrame → hitCount unchanged at that frame, +1 at the following startOfFrame.
- 20 frames each carrying a hit with MAX_HITS=15 → hitCount saturates at 15 and allPocketed=1. Pixel (16+14·16+3, 18) is lit; pixel (16+15·16, 18) is not.
- newGame pulse mid-frame with hitCount=7 → hitCount=0 on the next clock. Slot 0 goes dark from the next frame on, because displayCount reloads at startOfFrame.
- Blink build: a hit is committed, then the bench observes slot 0 over 32 frames → the slot alternates dark/lit every 4 frames, then stays lit.

Source files
------------

// File: rtl/pocket_hits_display_if.sv
// Bus between the pocket hit display and its scan/game-logic neighbours.
interface pocket_hits_display_if;
  logic               startOfFrame;
  logic [10:0]        pixelX;
  logic [10:0]        pixelY;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               ballInPocket;
  logic               newGame;
  logic [4:0]         hitCount;
  logic               allPocketed;
  logic               drawingRequest;
  logic [7:0]         RGBout;

  // Scan/game side: drives timing, pixel position, anchor and events.
  modport master (
    output startOfFrame, pixelX, pixelY, topLeftX, topLeftY, ballInPocket, newGame,
    input  hitCount, allPocketed, drawingRequest, RGBout
  );

  // Display side: consumes the above, returns count and draw request.
  modport slave (
    input  startOfFrame, pixelX, pixelY, topLeftX, topLeftY, ballInPocket, newGame,
    output hitCount, allPocketed, drawingRequest, RGBout
  );
endinterface

// File: rtl/pocket_hits_display.sv
// Pocket hit counter with a frame-synchronous row of marker squares.
// Optional feature macro: POCKET_HITS_BLINK_EN (newest marker blinks for
// BLINK_FRAMES frames after each committed hit).
module pocket_hits_display #(
  parameter int unsigned MAX_HITS     = 15,
  parameter int unsigned MARKER_SIZE  = 10,
  parameter logic [7:0]  MARKER_COLOR = 8'h00,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic                  clk,
  input  logic                  resetN,
  pocket_hits_display_if.slave  bus
);

  localparam int unsigned CW    = 5;
  localparam int unsigned PW    = 12;
  localparam logic [PW-1:0] ROW_W = PW'(MAX_HITS * 16);
  localparam logic [PW-1:0] ROW_H = PW'(MARKER_SIZE);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_HITS);
  localparam logic [4:0]    MSZ   = 5'(MARKER_SIZE);
  localparam int unsigned BLINK_W =
    ($clog2(BLINK_FRAMES + 1) < 3) ? 3 : $clog2(BLINK_FRAMES + 1);

  // Reject parameter values the geometry cannot represent.
  if (MAX_HITS < 1 || MAX_HITS > 31) begin : g_bad_max
    $error("MAX_HITS out of range 1..31");
  end
  if (MARKER_SIZE < 1 || MARKER_SIZE > 16) begin : g_bad_size
    $error("MARKER_SIZE out of range 1..16");
  end
  if (BLINK_FRAMES < 1 || BLINK_W > 16) begin : g_bad_blink
    $error("BLINK_FRAMES out of range");
  end

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] disp_q, disp_d;
  logic          pend_q, pend_d;
  logic          full_q, full_d;
  logic          sof_q;
  logic          commit_c;

  logic [PW-1:0] off_x_c, off_y_c;
  logic          in_row_c;
  logic [4:0]    slot_q;
  logic [3:0]    col_q;
  logic          in_row_q;

  logic          lit_c;
  logic          blank_c;
  logic          draw_q;
  logic [7:0]    rgb_q;

  // Hit accumulation, frame-synchronous commit and display copy.
  always_comb begin
    count_d  = count_q;
    pend_d   = pend_q;
    disp_d   = disp_q;
    commit_c = 1'b0;
    if (bus.newGame) begin
      count_d = '0;
      pend_d  = 1'b0;
    end else if (bus.startOfFrame) begin
      if (pend_q && (count_q < MAX_C)) begin
        count_d  = count_q + CW'(1);
        commit_c = 1'b1;
      end
      pend_d = bus.ballInPocket;
    end else if (bus.ballInPocket) begin
      pend_d = 1'b1;
    end
    if (sof_q) begin
      disp_d = count_q;
    end
    full_d = (count_d == MAX_C);
  end

  // Count, pending flag and display copy registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
      disp_q  <= '0;
      pend_q  <= 1'b0;
      full_q  <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      full_q  <= full_d;
      sof_q   <= bus.startOfFrame;
    end
  end

`ifdef POCKET_HITS_BLINK_EN
  logic [BLINK_W-1:0] blink_q, blink_d;

  // Blink window: reload on each committed hit, count frames down to zero.
  always_comb begin
    blink_d = blink_q;
    if (bus.newGame) begin
      blink_d = '0;
    end else if (commit_c) begin
      blink_d = BLINK_W'(BLINK_FRAMES);
    end else if (bus.startOfFrame && (blink_q != '0)) begin
      blink_d = blink_q - BLINK_W'(1);
    end
  end

  // Blink counter register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_d;
    end
  end

  // Newest marker is hidden on the odd 4-frame phases of the window.
  always_comb begin
    blank_c = (blink_q != '0) && blink_q[2] && (slot_q == (disp_q - CW'(1)));
  end
`else
  // All lit markers are steady.
  always_comb begin
    blank_c = 1'b0;
  end
`endif

  // Stage-1 geometry: signed offsets from the anchor and row bounds.
  always_comb begin
    off_x_c  = {1'b0, bus.pixelX} - {bus.topLeftX[10], bus.topLeftX};
    off_y_c  = {1'b0, bus.pixelY} - {bus.topLeftY[10], bus.topLeftY};
    in_row_c = !off_x_c[PW-1] && (off_x_c < ROW_W) &&
               !off_y_c[PW-1] && (off_y_c < ROW_H);
  end

  // Stage-1 registers: slot index, column within slot, row flag.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      slot_q   <= '0;
      col_q    <= '0;
      in_row_q <= 1'b0;
    end else begin
      slot_q   <= off_x_c[8:4];
      col_q    <= off_x_c[3:0];
      in_row_q <= in_row_c;
    end
  end

  // Stage-2 lit decision against the frame-stable display count.
  always_comb begin
    lit_c = in_row_q && ({1'b0, col_q} < MSZ) && (slot_q < disp_q) && !blank_c;
  end

  // Stage-2 output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      draw_q <= 1'b0;
      rgb_q  <= 8'hFF;
    end else begin
      draw_q <= lit_c;
      rgb_q  <= lit_c ? MARKER_COLOR : 8'hFF;
    end
  end

  assign bus.hitCount       = count_q;
  assign bus.allPocketed    = full_q;
  assign bus.drawingRequest = draw_q;
  assign bus.RGBout         = rgb_q;

endmodule

// File: tb/tb_pocket_hits_display.sv
// Directed bench for pocket_hits_display (default parameters).
module tb_pocket_hits_display;

  logic clk;
  logic resetN;
  int   n_checks = 0;
  int   n_passed = 0;

  pocket_hits_display_if bus ();

  pocket_hits_display #(
    .MAX_HITS     (15),
    .MARKER_SIZE  (10),
    .MARKER_COLOR (8'h00),
    .BLINK_FRAMES (32)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Present a pixel and check both draw outputs two clocks later.
  task automatic probe(input string tag, input int x, input int y, input logic exp);
    bus.pixelX = 11'(x);
    bus.pixelY = 11'(y);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_dr"}, 32'(bus.drawingRequest), 32'(exp));
    chk({tag, "_rgb"}, 32'(bus.RGBout), exp ? 32'h00 : 32'hFF);
  endtask

  // One startOfFrame pulse, optionally with a coincident hit.
  task automatic frame(input logic bip);
    bus.startOfFrame = 1'b1;
    bus.ballInPocket = bip;
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    bus.ballInPocket = 1'b0;
    @(negedge clk);
  endtask

  // One-clock hit mid-frame.
  task automatic hit();
    bus.ballInPocket = 1'b1;
    @(negedge clk);
    bus.ballInPocket = 1'b0;
    @(negedge clk);
  endtask

  task automatic new_game(input logic bip);
    bus.newGame      = 1'b1;
    bus.ballInPocket = bip;
    @(negedge clk);
    bus.newGame      = 1'b0;
    bus.ballInPocket = 1'b0;
  endtask

  initial begin
    resetN           = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.pixelX       = '0;
    bus.pixelY       = '0;
    bus.topLeftX     = 11'sd16;
    bus.topLeftY     = 11'sd16;
    bus.ballInPocket = 1'b0;
    bus.newGame      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hit", 32'(bus.hitCount), 32'd0);
    chk("rst_all", 32'(bus.allPocketed), 32'd0);
    chk("rst_dr", 32'(bus.drawingRequest), 32'd0);
    chk("rst_rgb", 32'(bus.RGBout), 32'hFF);
    resetN = 1'b1;
    @(negedge clk);

    probe("empty", 18, 18, 1'b0);

    // Long hit inside one frame counts once.
    bus.ballInPocket = 1'b1;
    repeat (500) @(negedge clk);
    bus.ballInPocket = 1'b0;
    @(negedge clk);
    chk("pre_commit", 32'(bus.hitCount), 32'd0);
    frame(1'b0);
    chk("one_hit", 32'(bus.hitCount), 32'd1);
    probe("s0_a", 18, 18, 1'b1);
    probe("s0_b", 25, 25, 1'b1);
    probe("gap", 30, 18, 1'b0);
    probe("s1", 34, 18, 1'b0);
    probe("below", 18, 26, 1'b0);

    // Hit coincident with startOfFrame waits for the next frame.
    frame(1'b1);
    chk("coinc_same", 32'(bus.hitCount), 32'd1);
    frame(1'b0);
    chk("coinc_next", 32'(bus.hitCount), 32'd2);

    // Saturation at MAX_HITS.
    for (int i = 0; i < 20; i++) begin
      hit();
      frame(1'b0);
      if (i == 11) begin
        chk("at14_cnt", 32'(bus.hitCount), 32'd14);
        chk("at14_all", 32'(bus.allPocketed), 32'd0);
      end
    end
    chk("sat_cnt", 32'(bus.hitCount), 32'd15);
    chk("sat_all", 32'(bus.allPocketed), 32'd1);
    probe("s14", 16 + 14 * 16 + 3, 18, 1'b1);
    probe("s15", 16 + 15 * 16, 18, 1'b0);

    // newGame mid-frame with a coincident hit.
    new_game(1'b0);
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      hit();
      frame(1'b0);
    end
    chk("seven", 32'(bus.hitCount), 32'd7);
    new_game(1'b1);
    chk("ng_clear", 32'(bus.hitCount), 32'd0);
    chk("ng_all", 32'(bus.allPocketed), 32'd0);
    probe("ng_still", 18, 18, 1'b1);
    frame(1'b0);
    chk("ng_drop", 32'(bus.hitCount), 32'd0);
    probe("ng_dark", 18, 18, 1'b0);

    // Negative anchor clips without wrapping.
    hit();
    frame(1'b0);
    bus.topLeftX = -11'sd8;
    probe("clip_in", 1, 18, 1'b1);
    probe("clip_gap", 2, 18, 1'b0);
    probe("clip_wrap", 2040, 18, 1'b0);
    bus.topLeftX = 11'sd16;

`ifdef POCKET_HITS_BLINK_EN
    // Newest marker blinks on 4-frame phases while the window runs.
    new_game(1'b0);
    @(negedge clk);
    hit();
    frame(1'b0);
    for (int k = 0; k < 36; k++) begin
      int   c;
      logic [31:0] cv;
      c  = (k < 32) ? 32 - k : 0;
      cv = 32'(c);
      probe($sformatf("blink%0d", k), 18, 18, !((c != 0) && cv[2]));
      frame(1'b0);
    end
`endif

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
